trigger_sequencer: RTL
======================

// Module: trigger_sequencer
// PURPOSE
//   Programmable multi-channel trigger generator on the 150 MHz clk_in domain. A shared phase counter
//   runs a configurable period; each channel emits a pulse of configurable width at its own offset.
//   Supports continuous or N-period burst runs with start/stop control and a done pulse.
//   Drives acquisition and transmit timing for downstream capture logic.
// PARAMETERS
//   CNT_W     20   phase-counter / period / offset width (max period 2^CNT_W-1)
//   NUM_CH    4    number of trigger output channels
//   PW_W      8    pulse-width field width, in clk_in cycles
//   BURST_W   16   burst-count field width; value 0 = continuous
// PORTS
//   clk_in        in   1              system clock, 150 MHz
//   rst_in        in   1              asynchronous, active-high reset
//   cfg_valid     in   1              config write request
//   cfg_ready     out  1              config accepted when valid&ready; high only in IDLE
//   cfg_period    in   CNT_W          period in cycles; values <2 are treated as 2
//   cfg_width     in   NUM_CH*PW_W    per-channel pulse width; 0 disables channel
//   cfg_offset    in   NUM_CH*CNT_W   per-channel rising-edge phase
//   cfg_burst     in   BURST_W        periods per run; 0 = run until stop
//   start         in   1              begin run (honoured in IDLE only)
//   stop          in   1              graceful stop request
//   busy          out  1              high in RUN
//   trigger       out  NUM_CH         registered trigger pulses
//   frame_start   out  1              1-cycle pulse when phase==0 (registered, aligned with trigger)
//   done          out  1              1-cycle pulse when a run ends
//   period_count  out  32             completed periods since start (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (async, any time incl. mid-run): state=IDLE, phase=0, burst_cnt=0, all outputs 0
//     except cfg_ready=1; config registers reset to period=150000, width[0]=1, others 0, offset 0, burst 0.
//   - FSM: IDLE -> RUN on start; RUN -> IDLE at end of period (phase==period-1) when
//     (burst!=0 && burst_cnt==burst-1) or stop_pend; done pulses on that transition edge (1 cycle).
//   - cfg handshake: registers latch on cfg_valid&cfg_ready; cfg_valid while busy is ignored (not queued).
//   - start sampled at edge k: RUN from edge k; phase=0 in cycle after k; increments each cycle,
//     wraps period-1 -> 0; burst_cnt increments on wrap.
//   - Output latency 1: trigger[c] high in cycle n+1 iff offset_c <= phase(n) < offset_c+width_c
//     and phase(n) < period. Windows never wrap past period-1 (clipped). offset_c >= period -> never fires.
//   - frame_start follows the same 1-cycle latency for phase==0.
//   - stop latched into stop_pend; run completes current period (no truncated pulses), then IDLE.
//     stop and start in same IDLE cycle: start wins, stop_pend set -> exactly one period runs.
//   - start while RUN ignored. All counter arithmetic unsigned, width CNT_W; offset+width computed CNT_W+1 bits.
//   - In IDLE trigger/frame_start are 0 (the final window, if any, drains on the cycle after exit).
// CONFIGURATION
//   TRIG_PERIOD_CNT_EN defined: period_count is a 32-bit counter, cleared on start, +1 on each
//     wrap/final period end, saturates at 2^32-1, holds value in IDLE.
//   Not defined: period_count tied to 0, counter logic absent.
// STRUCTURE
//   Package trigger_pkg: state_t enum {IDLE, RUN}; cfg_t struct (period, width[], offset[], burst);
//     localparam MIN_PERIOD=2, RESET_PERIOD=150000.
//   Sub-module trigger_channel: per-channel window compare + output register, generated NUM_CH times;
//     top holds FSM, phase/burst counters, config registers.
// TESTING
//   1 Reset defaults, start, run 3 periods -> trigger[0] 1-cycle pulse every 150000 cycles, first at
//     start edge+2; trigger[3:1]=0.
//   2 period=10, offsets {0,3,7,9}, widths {2,1,5,1}, burst=2 -> ch2 high phases 7-9 only (clipped);
//     exactly 2 periods; done 1 cycle after last phase 9; busy falls with done.
//   3 stop asserted at phase 4 of period=20 continuous run -> period finishes, done, IDLE; no partial pulse.
//   4 cfg_valid during RUN with period=5 -> cfg_ready=0, running period unchanged; after done write
//     accepted, next run uses 5.
//   5 rst_in pulsed mid-pulse (trigger high) -> trigger, busy low immediately (async), cfg back to defaults.
//   6 period=1, offset0=0, width0=3 -> treated as period 2, trigger[0] held high continuously;
//     with TRIG_PERIOD_CNT_EN, period_count=k after k periods; without, period_count=0.

Source files
------------

// File: rtl/trigger_sequencer_pkg.sv
// trigger_pkg: shared widths, FSM states and configuration record for trigger_sequencer.
package trigger_pkg;
    localparam int CNT_W   = 20;
    localparam int NUM_CH  = 4;
    localparam int PW_W    = 8;
    localparam int BURST_W = 16;
    localparam logic [CNT_W-1:0] MIN_PERIOD   = CNT_W'(2);
    localparam logic [CNT_W-1:0] RESET_PERIOD = CNT_W'(150000);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [CNT_W-1:0]               period;
        logic [NUM_CH-1:0][PW_W-1:0]    width;
        logic [NUM_CH-1:0][CNT_W-1:0]   offset;
        logic [BURST_W-1:0]             burst;
    } cfg_t;

    localparam cfg_t RESET_CFG = '{
        period: RESET_PERIOD,
        width:  (NUM_CH*PW_W)'(1),
        offset: '0,
        burst:  '0
    };

    function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] p);
        return (p < MIN_PERIOD) ? MIN_PERIOD : p;
    endfunction
endpackage

// File: rtl/trigger_sequencer_channel.sv
// trigger_channel: one trigger output; registers the phase-window hit, windows clipped at the period end.
module trigger_channel
    import trigger_pkg::*;
(
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_phase,
    input  logic [CNT_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_offset,
    input  logic [PW_W-1:0]  i_width,
    output logic             o_trig
);
    logic [CNT_W:0] w_end;
    logic           w_hit;

    // One extra bit so offset+width never wraps back into the period
    assign w_end = {1'b0, i_offset} + {{(CNT_W+1-PW_W){1'b0}}, i_width};
    assign w_hit = i_run && (i_phase >= i_offset) && ({1'b0, i_phase} < w_end) && (i_phase < i_period);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) o_trig <= 1'b0;
        else        o_trig <= w_hit;
    end
endmodule

// File: rtl/trigger_sequencer.sv
// trigger_sequencer: periodic multi-channel trigger generator with burst/continuous runs.
// Optional TRIG_PERIOD_CNT_EN enables the saturating completed-period counter on period_count.
module trigger_sequencer
    import trigger_pkg::*;
(
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CNT_W-1:0]        cfg_period,
    input  logic [NUM_CH*PW_W-1:0]  cfg_width,
    input  logic [NUM_CH*CNT_W-1:0] cfg_offset,
    input  logic [BURST_W-1:0]      cfg_burst,
    input  logic                    start,
    input  logic                    stop,
    output logic                    busy,
    output logic [NUM_CH-1:0]       trigger,
    output logic                    frame_start,
    output logic                    done,
    output logic [31:0]             period_count
);
    state_t             r_state, w_next;
    cfg_t               r_cfg;
    logic [CNT_W-1:0]   r_phase;
    logic [BURST_W-1:0] r_burst_cnt;
    logic               r_stop_pend, r_done, r_frame;
    logic [CNT_W-1:0]   w_period;
    logic               w_run, w_start, w_wrap, w_last;

    assign w_period = eff_period(r_cfg.period);
    assign w_run    = (r_state == RUN);
    assign w_start  = !w_run && start;
    assign w_wrap   = w_run && (r_phase == w_period - 1'b1);
    // A stop arriving on the final phase still ends this period rather than the next
    assign w_last   = w_wrap && (((r_cfg.burst != '0) && (r_burst_cnt == r_cfg.burst - 1'b1)) || r_stop_pend || stop);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_start)     w_next = RUN;
        else if (w_last) w_next = IDLE;
    end

    always_comb begin
        busy      = w_run;
        cfg_ready = !w_run;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cfg       <= RESET_CFG;
            r_phase     <= '0;
            r_burst_cnt <= '0;
            r_stop_pend <= 1'b0;
            r_done      <= 1'b0;
            r_frame     <= 1'b0;
        end else begin
            if (cfg_valid && cfg_ready)
                r_cfg <= '{period: cfg_period, width: cfg_width, offset: cfg_offset, burst: cfg_burst};
            r_phase     <= (!w_run || w_wrap) ? '0 : r_phase + 1'b1;
            r_burst_cnt <= w_start ? '0 : w_wrap ? r_burst_cnt + 1'b1 : r_burst_cnt;
            r_stop_pend <= w_start ? stop : w_last ? 1'b0 : (r_stop_pend || (w_run && stop));
            r_done      <= w_last;
            r_frame     <= w_run && (r_phase == '0);
        end
    end

    assign done        = r_done;
    assign frame_start = r_frame;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        trigger_channel u_ch (
            .clk_in   (clk_in),
            .rst_in   (rst_in),
            .i_run    (w_run),
            .i_phase  (r_phase),
            .i_period (w_period),
            .i_offset (r_cfg.offset[c]),
            .i_width  (r_cfg.width[c]),
            .o_trig   (trigger[c])
        );
    end

`ifdef TRIG_PERIOD_CNT_EN
    logic [31:0] r_pcnt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)                         r_pcnt <= '0;
        else if (w_start)                   r_pcnt <= '0;
        else if (w_wrap && (r_pcnt != '1))  r_pcnt <= r_pcnt + 1'b1;
    end

    assign period_count = r_pcnt;
`else
    assign period_count = '0;
`endif
endmodule
